la_capture_core: RTL and testbench

Capture engine of the logic analyzer; sits directly upstream of the UART LA host interface. It samples a 32-bit probe bus into a circular buffer and evaluates a masked trigger with a repeat qualifier. After the programmed post-trigger depth it stops, raises `finished`, and streams the captured words, oldest first, to the host interface on `data_read_strobe`.

---
 rtl/la_capture_core.sv | 152 +++++++++++++++
 tb/tb_la_capture_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: masked, repeat-qualified trigger into a circular buffer,
// oldest-first readout. Define LA_CAPTURE_EDGE_TRIGGER_EN for edge-qualified triggering.
module la_capture_core #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_cap_data,
  input  logic [31:0] i_trigger,
  input  logic [31:0] i_trigger_mask,
  input  logic [31:0] i_trigger_after,
  input  logic [31:0] i_repeat_count,
  input  logic        i_set_strobe,
  input  logic        i_enable,
  output logic        o_finished,
  output logic [31:0] o_data_read_size,
  input  logic        i_data_read_strobe,
  output logic [31:0] o_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] FILL_MAX = PW'(DEPTH);
  localparam logic [31:0]   AFTER_MAX = 32'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_trig, r_mask, r_after, r_repeat;
  logic [31:0]   r_rep_cnt, r_post_cnt, r_data, r_read_size;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_fill;
  logic          r_finished;
  logic [31:0]   r_mem [DEPTH];

  logic          w_match, w_qual, w_fire, w_wr_en;
  logic [PW-1:0] w_wr_next, w_rd_next, w_fill_next, w_rd_start;

  assign w_match = ((i_cap_data ^ r_trig) & r_mask) == 32'd0;

`ifdef LA_CAPTURE_EDGE_TRIGGER_EN
  logic r_prev_match;

  // Match history across ARMED cycles; IDLE clears it so the first armed match qualifies.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) r_prev_match <= 1'b0;
    else if (r_state == S_ARMED) r_prev_match <= w_match;
    else r_prev_match <= r_prev_match;
  end

  assign w_qual = w_match & ~r_prev_match;
`else
  assign w_qual = w_match;
`endif

  assign w_fire      = w_qual && (r_rep_cnt == r_repeat);
  assign w_wr_en     = !rst && !i_set_strobe && i_enable && (r_state == S_ARMED || r_state == S_POST);
  assign w_wr_next   = (r_wr_ptr == PTR_LAST) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
  assign w_rd_next   = (r_rd_ptr == PTR_LAST) ? {PW{1'b0}} : r_rd_ptr + PW'(1);
  assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + PW'(1);
  // Oldest valid word, computed from the pointer/fill values the final write produces.
  assign w_rd_start  = (w_wr_next - w_fill_next) & PTR_LAST;

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_cap_data;
  end

  // Control FSM, shadow config, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_trig <= 32'd0; r_mask <= 32'd0; r_after <= 32'd0; r_repeat <= 32'd0;
      r_rep_cnt <= 32'd0; r_post_cnt <= 32'd0; r_data <= 32'd0; r_read_size <= 32'd0;
      r_wr_ptr <= {PW{1'b0}}; r_rd_ptr <= {PW{1'b0}}; r_fill <= {PW{1'b0}};
      r_finished <= 1'b0;
    end else if (i_set_strobe) begin
      r_trig     <= i_trigger;
      r_mask     <= i_trigger_mask;
      r_after    <= (i_trigger_after > AFTER_MAX) ? AFTER_MAX : i_trigger_after;
      r_repeat   <= i_repeat_count;
      r_state    <= S_IDLE;
      r_finished <= 1'b0;
      r_read_size <= 32'd0;
      r_fill     <= {PW{1'b0}};
    end else if (!i_enable) begin
      r_state     <= S_IDLE;
      r_finished  <= 1'b0;
      r_read_size <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= S_ARMED;
          r_wr_ptr  <= {PW{1'b0}};
          r_fill    <= {PW{1'b0}};
          r_rep_cnt <= 32'd0;
        end
        S_ARMED: begin
          r_wr_ptr <= w_wr_next;
          r_fill   <= w_fill_next;
          if (w_fire) begin
            r_post_cnt <= r_after;
            if (r_after == 32'd0) begin
              r_state     <= S_DONE;
              r_finished  <= 1'b1;
              r_read_size <= 32'(w_fill_next);
              r_rd_ptr    <= w_rd_start;
            end else begin
              r_state <= S_POST;
            end
          end else if (w_qual) begin
            r_rep_cnt <= r_rep_cnt + 32'd1;
          end else begin
            r_rep_cnt <= 32'd0;
          end
        end
        S_POST: begin
          r_wr_ptr <= w_wr_next;
          r_fill   <= w_fill_next;
          if (r_post_cnt == 32'd1) begin
            r_state     <= S_DONE;
            r_finished  <= 1'b1;
            r_read_size <= 32'(w_fill_next);
            r_rd_ptr    <= w_rd_start;
          end else begin
            r_post_cnt <= r_post_cnt - 32'd1;
          end
        end
        S_DONE: begin
          if (i_data_read_strobe) begin
            r_data   <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
            r_rd_ptr <= w_rd_next;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_finished  <= 1'b0;
          r_read_size <= 32'd0;
        end
      endcase
    end
  end

  assign o_finished       = r_finished;
  assign o_data_read_size = r_read_size;
  assign o_data           = r_data;

endmodule

// File: tb/tb_la_capture_core.sv
// Self-checking bench for la_capture_core (DEPTH_LOG2 = 4): directed and random captures
// compared against a sample-sequence reference model of trigger/readout behaviour.
module tb_la_capture_core;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_cap_data, i_trigger, i_trigger_mask, i_trigger_after, i_repeat_count;
  logic        i_set_strobe, i_enable, i_data_read_strobe;
  logic        o_finished;
  logic [31:0] o_data_read_size, o_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] smp[$];
  logic [31:0] last_word = 32'd0;

  la_capture_core #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst),
    .i_cap_data(i_cap_data), .i_trigger(i_trigger), .i_trigger_mask(i_trigger_mask),
    .i_trigger_after(i_trigger_after), .i_repeat_count(i_repeat_count),
    .i_set_strobe(i_set_strobe), .i_enable(i_enable),
    .o_finished(o_finished), .o_data_read_size(o_data_read_size),
    .i_data_read_strobe(i_data_read_strobe), .o_data(o_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_match(input int j, input logic [31:0] trig, input logic [31:0] mask);
    return ((smp[j] ^ trig) & mask) == 32'd0;
  endfunction

  function automatic bit qualifies(input int j, input logic [31:0] trig, input logic [31:0] mask);
`ifdef LA_CAPTURE_EDGE_TRIGGER_EN
    return is_match(j, trig, mask) && !(j > 0 && is_match(j - 1, trig, mask));
`else
    return is_match(j, trig, mask);
`endif
  endfunction

  // Trigger is the first sample that ends a run of rep+1 consecutive qualifying samples.
  function automatic int trigger_index(input logic [31:0] trig, input logic [31:0] mask, input int rep);
    for (int i = 0; i < smp.size(); i++) begin
      int run;
      run = 0;
      for (int j = i; j >= 0; j--) begin
        if (!qualifies(j, trig, mask)) break;
        run++;
      end
      if (run == rep + 1) return i;
    end
    return -1;
  endfunction

  task automatic configure(input logic [31:0] trig, input logic [31:0] mask,
                           input logic [31:0] after, input logic [31:0] rep, input bit coincide);
    i_trigger = trig; i_trigger_mask = mask; i_trigger_after = after; i_repeat_count = rep;
    i_set_strobe = 1'b1; i_enable = coincide;
    step();
    i_set_strobe = 1'b0; i_enable = 1'b1;
    step();
  endtask

  task automatic capture(input string name, input logic [31:0] trig, input logic [31:0] mask,
                         input int after, input int rep, input bit do_cfg, input bit coincide);
    int t, last, eff, len, base;
    if (do_cfg) configure(trig, mask, 32'(after), 32'(rep), coincide);
    else begin
      i_enable = 1'b1;
      step();
    end
    eff  = (after > DEPTH - 1) ? DEPTH - 1 : after;
    t    = trigger_index(trig, mask, rep);
    last = (t < 0) ? -1 : t + eff;
    while (int'(smp.size()) <= last) smp.push_back($urandom());
    for (int i = 0; i < smp.size(); i++) begin
      i_cap_data = smp[i];
      step();
      check({name, "/finished"}, 32'(o_finished), (i == last) ? 32'd1 : 32'd0);
      if (i == last) break;
    end
    if (last < 0) begin
      check({name, "/size_notrig"}, o_data_read_size, 32'd0);
      i_enable = 1'b0;
      step();
      return;
    end
    len  = (last + 1 < DEPTH) ? last + 1 : DEPTH;
    base = last + 1 - len;
    check({name, "/size"}, o_data_read_size, 32'(len));
    i_data_read_strobe = 1'b1;
    for (int k = 0; k < len; k++) begin
      step();
      check($sformatf("%s/rd%0d", name, k), o_data, smp[base + k]);
    end
    if (len == DEPTH) begin
      step();
      check({name, "/wrap"}, o_data, smp[base]);
      last_word = smp[base];
    end else begin
      last_word = smp[base + len - 1];
    end
    i_data_read_strobe = 1'b0;
    step();
    check({name, "/hold"}, o_data, last_word);
  endtask

  initial begin
    rst = 1'b1;
    i_cap_data = 32'd0; i_trigger = 32'd0; i_trigger_mask = 32'd0; i_trigger_after = 32'd0;
    i_repeat_count = 32'd0; i_set_strobe = 1'b0; i_enable = 1'b0; i_data_read_strobe = 1'b0;
    step();
    step();
    check("rst/finished", 32'(o_finished), 32'd0);
    check("rst/data", o_data, 32'd0);
    check("rst/size", o_data_read_size, 32'd0);
    rst = 1'b0;

    // Counter on the probe bus, trigger at 0xA5.
    smp.delete();
    for (int i = 0; i < 64; i++) smp.push_back(32'h80 + 32'(i));
    capture("t1_counter", 32'hA5, 32'hFF, 3, 0, 1'b1, 1'b0);

    // Bit0 pattern 1,1,0,1,1,1 with repeat 2.
    smp.delete();
    begin
      logic [31:0] pat;
      pat = 32'b111011;
      for (int i = 0; i < 6; i++) smp.push_back(($urandom() & 32'hFFFF_FFFE) | 32'(pat[i]));
      for (int i = 0; i < 10; i++) smp.push_back($urandom() & 32'hFFFF_FFFE);
    end
    capture("t2_repeat", 32'h1, 32'h1, 2, 2, 1'b1, 1'b0);

    // Mask 0 fires on the first armed cycle; also set_strobe coincident with enable.
    smp.delete();
    for (int i = 0; i < 4; i++) smp.push_back($urandom());
    capture("t3_mask0", 32'h0, 32'h0, 0, 0, 1'b1, 1'b1);

    // Post-trigger depth clamped to DEPTH-1.
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back($urandom() & 32'h0FFF_FFFF);
    smp.push_back(32'h1234_5678);
    for (int i = 0; i < 30; i++) smp.push_back($urandom() & 32'h0FFF_FFFF);
    capture("t4_clamp", 32'h1234_5678, 32'hFFFF_FFFF, 100, 0, 1'b1, 1'b0);

    // Drop enable mid-POST, strobe while idle, then re-arm without reconfiguring.
    smp.delete();
    for (int i = 0; i < 10; i++) smp.push_back($urandom() & 32'h0FFF_FFFF);
    smp.push_back(32'hDEAD_BEEF);
    smp.push_back(32'h0000_0001);
    smp.push_back(32'h0000_0002);
    configure(32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      i_cap_data = smp[i];
      step();
      check("t5_post/finished", 32'(o_finished), 32'd0);
    end
    i_enable = 1'b0;
    step();
    check("t5_drop/finished", 32'(o_finished), 32'd0);
    check("t5_drop/size", o_data_read_size, 32'd0);
    i_data_read_strobe = 1'b1;
    step();
    i_data_read_strobe = 1'b0;
    check("t5_idle_strobe/data", o_data, last_word);
    smp.delete();
    for (int i = 0; i < 3; i++) smp.push_back($urandom() & 32'h0FFF_FFFF);
    smp.push_back(32'hDEAD_BEEF);
    capture("t5_rearm", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5, 0, 1'b0, 1'b0);
    i_set_strobe = 1'b1;
    step();
    i_set_strobe = 1'b0;
    check("t5_set_in_done/finished", 32'(o_finished), 32'd0);
    check("t5_set_in_done/size", o_data_read_size, 32'd0);
    i_enable = 1'b0;
    step();

`ifdef LA_CAPTURE_EDGE_TRIGGER_EN
    // Constant matching value: edge fires on the first armed cycle only.
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(32'hA5);
    capture("t6_hold", 32'hA5, 32'hFF, 2, 0, 1'b1, 1'b0);
    smp.delete();
    smp.push_back(32'h00); smp.push_back(32'hA5); smp.push_back(32'hA5);
    smp.push_back(32'h00); smp.push_back(32'hA5); smp.push_back(32'hA5);
    smp.push_back(32'h00); smp.push_back(32'hA5);
    capture("t6_edges", 32'hA5, 32'hFF, 1, 1, 1'b1, 1'b0);
`endif

    // Random configurations with biased sample low bits so triggers are likely.
    for (int it = 0; it < 10; it++) begin
      logic [31:0] trig, mask;
      int after, rep;
      trig  = $urandom() & 32'hFFFF_FFF9;
      mask  = (it == 3) ? 32'd0 : ($urandom() & 32'h0000_0007);
      rep   = $urandom_range(0, 2);
      after = $urandom_range(0, 20);
      smp.delete();
      for (int i = 0; i < 48; i++) smp.push_back(($urandom() & 32'hFFFF_FFF8) | 32'($urandom_range(0, 1)));
      capture($sformatf("rnd%0d", it), trig, mask, after, rep, 1'b1, bit'(it % 2));
    end

    // Reset during readout returns outputs to their reset values.
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back($urandom() | 32'h8000_0000);
    capture("t7_pre_rst", 32'h0, 32'h0, 3, 0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_rst/finished", 32'(o_finished), 32'd0);
    check("t7_rst/data", o_data, 32'd0);
    check("t7_rst/size", o_data_read_size, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
